// File: rtl/load_store_unit.sv
// Load/store unit: one memory op at a time, aligned byte-lane bus, with
// size/alignment checking, load extension and flush suppression of responses.
module load_store_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    input  logic              flush,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [XLEN/8-1:0] mem_wmask,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              resp_valid,
    output logic              resp_load,
    output logic [4:0]        resp_rd,
    output logic [XLEN-1:0]   resp_data,
    output logic [1:0]        resp_err,
    output logic              busy
);
    localparam int NB = XLEN / 8;
    localparam int LB = $clog2(NB);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("load_store_unit: XLEN must be 32 or 64");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_ERR} state_t;

    state_t            r_state, w_next;
    logic              r_we, r_kill;
    logic [2:0]        r_funct3;
    logic [LB-1:0]     r_lane;
    logic [4:0]        r_rd;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [NB-1:0]     r_wmask;
    logic [XLEN-1:0]   r_wdata;
    logic              r_resp_load;
    logic [4:0]        r_resp_rd;
    logic [XLEN-1:0]   r_resp_data;
    logic [1:0]        r_resp_err;

    logic              w_accept, w_legal, w_misal, w_kill;
    logic [1:0]        w_err;
    logic [2:0]        w_align;
    logic [7:0]        w_smask;
    logic [LB-1:0]     w_lane;
    logic [NB-1:0]     w_wmask;
    logic [XLEN-1:0]   w_wdata, w_rshift;
    logic              w_resp_upd, w_resp_load;
    logic [4:0]        w_resp_rd;
    logic [XLEN-1:0]   w_resp_data;
    logic [1:0]        w_resp_err;

    function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3, input logic [XLEN-1:0] d);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] w;
        b = d[7:0];
        h = d[15:0];
        w = d[31:0];
        case (f3)
            3'b000:  load_extend = XLEN'(b);
            3'b001:  load_extend = XLEN'(h);
            3'b010:  load_extend = XLEN'(w);
            3'b100:  load_extend = XLEN'(d[7:0]);
            3'b101:  load_extend = XLEN'(d[15:0]);
            3'b110:  load_extend = XLEN'(d[31:0]);
            default: load_extend = d;
        endcase
    endfunction

    assign w_accept = req_valid && (r_state == S_IDLE);
    assign w_lane   = req_addr[LB-1:0];
    assign w_kill   = r_kill || flush;
    assign w_rshift = mem_rdata >> {r_lane, 3'b000};

    // Doubleword encodings only exist on a 64-bit datapath.
    always_comb begin
        w_legal = 1'b0;
        if (req_we) begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010: w_legal = 1'b1;
                3'b011:                 w_legal = (XLEN == 64);
                default:                w_legal = 1'b0;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
                3'b011, 3'b110:                         w_legal = (XLEN == 64);
                default:                                w_legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_align = 3'b000;
        w_smask = 8'h01;
        case (req_funct3[1:0])
            2'b00: begin w_align = 3'b000; w_smask = 8'h01; end
            2'b01: begin w_align = 3'b001; w_smask = 8'h03; end
            2'b10: begin w_align = 3'b011; w_smask = 8'h0F; end
            default: begin w_align = 3'b111; w_smask = 8'hFF; end
        endcase
    end

    assign w_misal = |(req_addr[2:0] & w_align);
    assign w_err   = !w_legal ? 2'b10 : (w_misal ? 2'b01 : 2'b00);
    assign w_wmask = req_we ? (NB'(w_smask) << w_lane) : '0;
    assign w_wdata = req_wdata << {w_lane, 3'b000};

    // A flushed op still finishes its bus transaction but skips RESP entirely.
    always_comb begin
        w_next      = r_state;
        w_resp_upd  = 1'b0;
        w_resp_load = 1'b0;
        w_resp_rd   = r_rd;
        w_resp_data = '0;
        w_resp_err  = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_err != 2'b00) begin
                        w_next     = S_ERR;
                        w_resp_upd = 1'b1;
                        w_resp_rd  = req_rd;
                        w_resp_err = w_err;
                    end else begin
                        w_next = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    if (!r_we) begin
                        w_next = S_WAIT;
                    end else if (w_kill) begin
                        w_next = S_IDLE;
                    end else begin
                        w_next     = S_RESP;
                        w_resp_upd = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    if (w_kill) begin
                        w_next = S_IDLE;
                    end else begin
                        w_next      = S_RESP;
                        w_resp_upd  = 1'b1;
                        w_resp_load = 1'b1;
                        w_resp_data = load_extend(r_funct3, w_rshift);
                    end
                end
            end
            S_RESP:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_kill      <= 1'b0;
            r_funct3    <= 3'b000;
            r_lane      <= '0;
            r_rd        <= 5'd0;
            r_mem_addr  <= '0;
            r_wmask     <= '0;
            r_wdata     <= '0;
            r_resp_load <= 1'b0;
            r_resp_rd   <= 5'd0;
            r_resp_data <= '0;
            r_resp_err  <= 2'b00;
        end else begin
            if (w_accept) begin
                r_we       <= req_we;
                r_kill     <= 1'b0;
                r_funct3   <= req_funct3;
                r_lane     <= w_lane;
                r_rd       <= req_rd;
                r_mem_addr <= {req_addr[ADDR_W-1:LB], {LB{1'b0}}};
                r_wmask    <= w_wmask;
                r_wdata    <= w_wdata;
            end else if (flush && (r_state == S_REQ || r_state == S_WAIT)) begin
                r_kill <= 1'b1;
            end
            if (w_resp_upd) begin
                r_resp_load <= w_resp_load;
                r_resp_rd   <= w_resp_rd;
                r_resp_data <= w_resp_data;
                r_resp_err  <= w_resp_err;
            end
        end
    end

    // req_ready is held low while reset is asserted.
    assign req_ready  = rst_n && (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign mem_valid  = (r_state == S_REQ);
    assign mem_addr   = r_mem_addr;
    assign mem_we     = r_we;
    assign mem_wmask  = r_wmask;
    assign mem_wdata  = r_wdata;
    assign resp_valid = (r_state == S_RESP) || (r_state == S_ERR);
    assign resp_load  = r_resp_load;
    assign resp_rd    = r_resp_rd;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;

endmodule
